sys_ctrl: RTL and testbench
===========================

# sys_ctrl

Command controller between the UART receiver and the register file / ALU. It parses framed command bytes from the RX deserializer and issues register-file writes and reads and ALU operations. It then returns read data and ALU results as bytes to the TX FIFO. It is the only master of the register-file port and of the ALU enable.

## Interface
- `DATA_WIDTH`, 8: RX/TX byte width and register-file word width.
- `ADDR_WIDTH`, 4: register-file address width.
- `FUN_WIDTH`, 4: ALU function code width.
- `CLK` in 1: single clock for all logic.
- `RST` in 1: reset, synchronous and active-high.
- `RX_P_DATA` in DATA_WIDTH: received byte.
- `RX_D_VLD` in 1: one-cycle strobe, RX_P_DATA valid.
- `WrEn` out 1: register-file write strobe.
- `RdEn` out 1: register-file read strobe.
- `Address` out ADDR_WIDTH: register-file address.
- `WrData` out DATA_WIDTH: register-file write data.
- `RdData` in DATA_WIDTH: register-file read data.
- `RdData_Valid` in 1: read data valid.
- `ALU_EN` out 1: one-cycle ALU start.
- `ALU_FUN` out FUN_WIDTH: ALU function.
- `ALU_OUT` in 2*DATA_WIDTH: ALU result.
- `ALU_OUT_VLD` in 1: ALU result valid.
- `CLK_GATE_EN` out 1: ALU clock-gate enable.
- `TX_P_DATA` out DATA_WIDTH: byte to TX FIFO.
- `TX_D_VLD` out 1: write strobe to TX FIFO.
- `FIFO_FULL` in 1: TX FIFO full; no push while high.

## Operation
- Command bytes:
  - 0xAA, RF write: frame is addr, data.
  - 0xBB, RF read: frame is addr.
  - 0xCC, ALU with operands: frame is opA, opB, fun.
  - 0xDD, ALU without operands: frame is fun.
- Any other byte in IDLE is dropped and the FSM stays in IDLE.
- Addresses use byte bits [ADDR_WIDTH-1:0]. Upper bits are ignored.
- The fun byte uses bits [FUN_WIDTH-1:0].
- States are IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, FUN, ALU_WAIT, TX_LO, TX_HI, TX_RD.
- RF write:
  - IDLE→WR_ADDR on 0xAA.
  - Address byte latched, then WR_DATA.
  - Data byte causes a WrEn pulse with that Address/WrData, then IDLE.
- RF read:
  - IDLE→RD_ADDR on 0xBB.
  - Address byte causes a RdEn pulse, then RD_WAIT.
  - On RdData_Valid, RdData is latched, then TX_RD.
  - In TX_RD the byte is pushed when FIFO_FULL=0, then IDLE.
- ALU with operands:
  - IDLE→OP_A on 0xCC.
  - opA byte causes WrEn to address 0, then OP_B.
  - opB byte causes WrEn to address 1, then FUN.
- ALU without operands: IDLE→FUN on 0xDD.
- FUN state:
  - The fun byte is latched into ALU_FUN and ALU_EN pulses, then ALU_WAIT.
  - On ALU_OUT_VLD the 16-bit result is latched, then TX_LO.
  - TX_LO pushes the low byte; TX_HI pushes the high byte; then IDLE.
- CLK_GATE_EN is high from entry to FUN until the cycle ALU_OUT_VLD is sampled, inclusive.
- RX bytes arriving in RD_WAIT, ALU_WAIT or any TX state are dropped. They do not queue.
- WrEn and RdEn are never high together. At most one TX_D_VLD is issued per cycle.

## Timing
- All outputs are registered. Reset values:
  - WrEn, RdEn, ALU_EN, TX_D_VLD, CLK_GATE_EN: 0.
  - Address, WrData, ALU_FUN, TX_P_DATA: 0.
  - State: IDLE.
- WrEn and RdEn assert the cycle after the RX_D_VLD that completes the field, for exactly one cycle.
- ALU_EN asserts the cycle after the fun byte's RX_D_VLD, for exactly one cycle.
- Address/WrData/ALU_FUN are stable during their strobe and hold until the next update.
- TX_D_VLD is a one-cycle pulse. It is issued only in a cycle where FIFO_FULL=0 was sampled. While FIFO_FULL=1 the FSM waits and the pending byte is held.
- Minimum spacing:
  - Result latch → TX_LO push: 1 cycle.
  - Low byte → high byte: at least 1 cycle.
- RdData_Valid or ALU_OUT_VLD outside the matching wait state is ignored.
- RST asserted mid-frame or mid-transmit returns the block to IDLE on the next edge with all strobes low. A partial frame is discarded and its pending TX bytes are lost.

## Structure
- The shared package holds:
  - Command opcodes 0xAA/0xBB/0xCC/0xDD.
  - ALU operand addresses 0 and 1.
  - The state enumeration.
- A single module is used. An optional sub-module `sys_ctrl_tx_mux` selects the TX byte among read data, result low byte and result high byte.

## Test plan
- AA, 05, 3C → one-cycle WrEn with Address=5, WrData=0x3C; no TX; back in IDLE.
- BB, 02 with RF returning 0x7E two cycles later → one RdEn with Address=2; one push TX_P_DATA=0x7E.
- CC, 0A, 03, 00, ALU returns 0x000D → WrEn with address 0 / data 0x0A, then WrEn with address 1 / data 0x03; ALU_EN with ALU_FUN=0; pushes 0x0D then 0x00.
- DD, 02 with FIFO_FULL held high for 10 cycles after the result → no TX_D_VLD while full; then two pushes of the latched bytes in order.
- Byte 0x55 in IDLE, and a byte during ALU_WAIT → both ignored; no strobes.
- RST high after AA, 05 → IDLE with outputs at reset values; subsequent AA, 01, FF completes normally.

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
// rtl/sys_ctrl_pkg.sv - shared constants and types for the command controller
// Contents: command opcodes, ALU operand register addresses,
//           controller state enumeration, TX byte source select.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;  // frame: addr, data
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;  // frame: addr
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;  // frame: opA, opB, fun
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;  // frame: fun

  localparam int ALU_OPA_ADDR = 0;
  localparam int ALU_OPB_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    OP_A,
    OP_B,
    FUN,
    ALU_WAIT,
    TX_LO,
    TX_HI,
    TX_RD
  } state_t;

  typedef enum logic [1:0] {
    TX_SEL_RD,
    TX_SEL_LO,
    TX_SEL_HI
  } tx_sel_t;

endpackage

// File: rtl/sys_ctrl_tx_mux.sv
// rtl/sys_ctrl_tx_mux.sv - selects the byte offered to the TX FIFO
// Ports: sel     - source select (tx_sel_t encoding)
//        rd_data - latched register-file read data
//        result  - latched 2*DATA_WIDTH ALU result
//        tx_byte - selected byte
module sys_ctrl_tx_mux
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [1:0]              sel,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  input  logic [2*DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0]   tx_byte
);

  always_comb begin
    tx_byte = '0;
    case (tx_sel_t'(sel))
      TX_SEL_RD: tx_byte = rd_data;
      TX_SEL_LO: tx_byte = result[DATA_WIDTH-1:0];
      TX_SEL_HI: tx_byte = result[2*DATA_WIDTH-1:DATA_WIDTH];
      default:   tx_byte = '0;
    endcase
  end

endmodule

// File: rtl/sys_ctrl.sv
// rtl/sys_ctrl.sv - UART command parser driving register file, ALU and TX FIFO
// Ports: CLK/RST                  - clock, synchronous active-high reset
//        RX_P_DATA/RX_D_VLD       - received byte and its strobe
//        WrEn/RdEn/Address/WrData - register-file port (this block is sole master)
//        RdData/RdData_Valid      - register-file read return
//        ALU_EN/ALU_FUN           - ALU start strobe and function
//        ALU_OUT/ALU_OUT_VLD      - ALU result return
//        CLK_GATE_EN              - ALU clock-gate enable
//        TX_P_DATA/TX_D_VLD       - byte push to TX FIFO
//        FIFO_FULL                - TX FIFO full, blocks pushes
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic                    WrEn,
  output logic                    RdEn,
  output logic [ADDR_WIDTH-1:0]   Address,
  output logic [DATA_WIDTH-1:0]   WrData,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_Valid,
  output logic                    ALU_EN,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  output logic                    CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  input  logic                    FIFO_FULL
);

  state_t                  state;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic [2*DATA_WIDTH-1:0] result_q;
  tx_sel_t                 tx_sel;
  logic [DATA_WIDTH-1:0]   tx_byte;

  always_comb begin
    tx_sel = TX_SEL_RD;
    case (state)
      TX_LO:   tx_sel = TX_SEL_LO;
      TX_HI:   tx_sel = TX_SEL_HI;
      default: tx_sel = TX_SEL_RD;
    endcase
  end

  sys_ctrl_tx_mux #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tx_mux (
    .sel     (tx_sel),
    .rd_data (rd_data_q),
    .result  (result_q),
    .tx_byte (tx_byte)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      WrEn        <= 1'b0;
      RdEn        <= 1'b0;
      ALU_EN      <= 1'b0;
      TX_D_VLD    <= 1'b0;
      CLK_GATE_EN <= 1'b0;
      Address     <= '0;
      WrData      <= '0;
      ALU_FUN     <= '0;
      TX_P_DATA   <= '0;
      rd_data_q   <= '0;
      result_q    <= '0;
    end else begin
      // Strobes are single-cycle; any state that fires one re-asserts it.
      WrEn     <= 1'b0;
      RdEn     <= 1'b0;
      ALU_EN   <= 1'b0;
      TX_D_VLD <= 1'b0;

      case (state)
        IDLE: begin
          if (RX_D_VLD) begin
            case (RX_P_DATA)
              CMD_RF_WR:  state <= WR_ADDR;
              CMD_RF_RD:  state <= RD_ADDR;
              CMD_ALU_OP: state <= OP_A;
              CMD_ALU_NOP: begin
                state       <= FUN;
                CLK_GATE_EN <= 1'b1;
              end
              default:    state <= IDLE;
            endcase
          end
        end

        WR_ADDR: begin
          if (RX_D_VLD) begin
            Address <= RX_P_DATA[ADDR_WIDTH-1:0];
            state   <= WR_DATA;
          end
        end

        WR_DATA: begin
          if (RX_D_VLD) begin
            WrData <= RX_P_DATA;
            WrEn   <= 1'b1;
            state  <= IDLE;
          end
        end

        RD_ADDR: begin
          if (RX_D_VLD) begin
            Address <= RX_P_DATA[ADDR_WIDTH-1:0];
            RdEn    <= 1'b1;
            state   <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (RdData_Valid) begin
            rd_data_q <= RdData;
            state     <= TX_RD;
          end
        end

        TX_RD: begin
          if (!FIFO_FULL) begin
            TX_P_DATA <= tx_byte;
            TX_D_VLD  <= 1'b1;
            state     <= IDLE;
          end
        end

        OP_A: begin
          if (RX_D_VLD) begin
            Address <= ADDR_WIDTH'(ALU_OPA_ADDR);
            WrData  <= RX_P_DATA;
            WrEn    <= 1'b1;
            state   <= OP_B;
          end
        end

        OP_B: begin
          if (RX_D_VLD) begin
            Address     <= ADDR_WIDTH'(ALU_OPB_ADDR);
            WrData      <= RX_P_DATA;
            WrEn        <= 1'b1;
            CLK_GATE_EN <= 1'b1;
            state       <= FUN;
          end
        end

        FUN: begin
          if (RX_D_VLD) begin
            ALU_FUN <= RX_P_DATA[FUN_WIDTH-1:0];
            ALU_EN  <= 1'b1;
            state   <= ALU_WAIT;
          end
        end

        ALU_WAIT: begin
          // Gate stays open through the cycle the result is sampled.
          if (ALU_OUT_VLD) begin
            result_q    <= ALU_OUT;
            CLK_GATE_EN <= 1'b0;
            state       <= TX_LO;
          end
        end

        TX_LO: begin
          if (!FIFO_FULL) begin
            TX_P_DATA <= tx_byte;
            TX_D_VLD  <= 1'b1;
            state     <= TX_HI;
          end
        end

        TX_HI: begin
          // Waiting for TX_D_VLD to drop keeps the two pushes as separate
          // pulses with an idle cycle between them.
          if (!FIFO_FULL && !TX_D_VLD) begin
            TX_P_DATA <= tx_byte;
            TX_D_VLD  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_ctrl.sv
// tb/tb_sys_ctrl.sv - directed self-checking bench for sys_ctrl
module tb_sys_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic        WrEn;
  logic        RdEn;
  logic [3:0]  Address;
  logic [7:0]  WrData;
  logic [7:0]  RdData;
  logic        RdData_Valid;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic        CLK_GATE_EN;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        FIFO_FULL;

  always #5 CLK = ~CLK;

  sys_ctrl dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_P_DATA    (RX_P_DATA),
    .RX_D_VLD     (RX_D_VLD),
    .WrEn         (WrEn),
    .RdEn         (RdEn),
    .Address      (Address),
    .WrData       (WrData),
    .RdData       (RdData),
    .RdData_Valid (RdData_Valid),
    .ALU_EN       (ALU_EN),
    .ALU_FUN      (ALU_FUN),
    .ALU_OUT      (ALU_OUT),
    .ALU_OUT_VLD  (ALU_OUT_VLD),
    .CLK_GATE_EN  (CLK_GATE_EN),
    .TX_P_DATA    (TX_P_DATA),
    .TX_D_VLD     (TX_D_VLD),
    .FIFO_FULL    (FIFO_FULL)
  );

  int errors = 0;
  int checks = 0;

  int          wr_cnt, rd_cnt, alu_cnt, both_hi, tx_while_full;
  logic [11:0] wr_q[$];
  logic [7:0]  tx_q[$];
  logic [3:0]  rd_addr_last, fun_last;
  logic        full_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Event log sampled away from the active edge.
  always @(negedge CLK) begin
    if (WrEn) begin
      wr_cnt++;
      wr_q.push_back({Address, WrData});
    end
    if (RdEn) begin
      rd_cnt++;
      rd_addr_last = Address;
    end
    if (ALU_EN) begin
      alu_cnt++;
      fun_last = ALU_FUN;
    end
    if (WrEn && RdEn) both_hi++;
    if (TX_D_VLD) begin
      tx_q.push_back(TX_P_DATA);
      if (full_q) tx_while_full++;
    end
  end

  // FIFO_FULL as seen by the DUT at the edge that produced the current outputs.
  always @(posedge CLK) full_q <= FIFO_FULL;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
  endtask

  task automatic clear_log();
    wr_cnt = 0;
    rd_cnt = 0;
    alu_cnt = 0;
    wr_q.delete();
    tx_q.delete();
  endtask

  task automatic alu_result(input logic [15:0] r);
    ALU_OUT     = r;
    ALU_OUT_VLD = 1'b1;
    tick();
    ALU_OUT_VLD = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_strobes"}, {WrEn, RdEn, ALU_EN, TX_D_VLD, CLK_GATE_EN}, 5'b0);
    check({tag, "_addr"}, Address, 4'h0);
    check({tag, "_wrdata"}, WrData, 8'h00);
    check({tag, "_fun"}, ALU_FUN, 4'h0);
    check({tag, "_txdata"}, TX_P_DATA, 8'h00);
  endtask

  initial begin
    both_hi = 0;
    tx_while_full = 0;
    clear_log();
    RST = 1'b1;
    RX_P_DATA = 8'h00;
    RX_D_VLD = 1'b0;
    RdData = 8'h00;
    RdData_Valid = 1'b0;
    ALU_OUT = 16'h0000;
    ALU_OUT_VLD = 1'b0;
    FIFO_FULL = 1'b0;
    idle(3);
    check_reset_outputs("reset");
    RST = 1'b0;
    idle(2);

    // RF write: AA, 05, 3C
    clear_log();
    send(8'hAA);
    send(8'h05);
    send(8'h3C);
    check("wr_strobe", WrEn, 1'b1);
    check("wr_addr", Address, 4'h5);
    check("wr_data", WrData, 8'h3C);
    tick();
    check("wr_strobe_drop", WrEn, 1'b0);
    idle(4);
    check("wr_count", wr_cnt, 1);
    check("wr_no_tx", tx_q.size(), 0);

    // RF read: BB, 02, RF returns 0x7E two cycles after RdEn
    clear_log();
    send(8'hBB);
    send(8'h02);
    check("rd_strobe", RdEn, 1'b1);
    check("rd_addr", Address, 4'h2);
    tick();
    RdData = 8'h7E;
    RdData_Valid = 1'b1;
    tick();
    RdData_Valid = 1'b0;
    idle(5);
    check("rd_count", rd_cnt, 1);
    check("rd_addr_log", rd_addr_last, 4'h2);
    check("rd_tx_count", tx_q.size(), 1);
    check("rd_tx_byte", tx_q.size() > 0 ? tx_q[0] : 8'hxx, 8'h7E);
    check("rd_no_wr", wr_cnt, 0);

    // ALU with operands: CC, 0A, 03, 00 -> 0x000D
    clear_log();
    send(8'hCC);
    send(8'h0A);
    send(8'h03);
    check("cc_gate_on", CLK_GATE_EN, 1'b1);
    send(8'h00);
    check("cc_alu_en", ALU_EN, 1'b1);
    check("cc_alu_fun", ALU_FUN, 4'h0);
    tick();
    check("cc_alu_en_drop", ALU_EN, 1'b0);
    check("cc_gate_wait", CLK_GATE_EN, 1'b1);
    alu_result(16'h000D);
    check("cc_gate_off", CLK_GATE_EN, 1'b0);
    idle(6);
    check("cc_wr_count", wr_cnt, 2);
    check("cc_wr0", wr_q.size() > 0 ? wr_q[0] : 12'hxxx, {4'h0, 8'h0A});
    check("cc_wr1", wr_q.size() > 1 ? wr_q[1] : 12'hxxx, {4'h1, 8'h03});
    check("cc_alu_count", alu_cnt, 1);
    check("cc_tx_count", tx_q.size(), 2);
    check("cc_tx_lo", tx_q.size() > 0 ? tx_q[0] : 8'hxx, 8'h0D);
    check("cc_tx_hi", tx_q.size() > 1 ? tx_q[1] : 8'hxx, 8'h00);

    // ALU without operands, FIFO full for 10 cycles after the result
    clear_log();
    send(8'hDD);
    check("dd_gate_on", CLK_GATE_EN, 1'b1);
    send(8'h02);
    check("dd_alu_fun", ALU_FUN, 4'h2);
    FIFO_FULL = 1'b1;
    idle(2);
    alu_result(16'h1234);
    idle(10);
    check("dd_no_tx_full", tx_q.size(), 0);
    FIFO_FULL = 1'b0;
    idle(6);
    check("dd_wr_count", wr_cnt, 0);
    check("dd_tx_count", tx_q.size(), 2);
    check("dd_tx_lo", tx_q.size() > 0 ? tx_q[0] : 8'hxx, 8'h34);
    check("dd_tx_hi", tx_q.size() > 1 ? tx_q[1] : 8'hxx, 8'h12);

    // Ignored bytes: 0x55 in IDLE, stray read-valid in IDLE, byte in ALU_WAIT
    clear_log();
    send(8'h55);
    RdData = 8'h99;
    RdData_Valid = 1'b1;
    tick();
    RdData_Valid = 1'b0;
    idle(3);
    check("ign_idle_tx", tx_q.size(), 0);
    check("ign_idle_gate", CLK_GATE_EN, 1'b0);
    send(8'hDD);
    send(8'h01);
    idle(1);
    send(8'hAA);
    idle(1);
    alu_result(16'h00FF);
    idle(6);
    check("ign_wr_count", wr_cnt, 0);
    check("ign_rd_count", rd_cnt, 0);
    check("ign_alu_count", alu_cnt, 1);
    check("ign_alu_fun", fun_last, 4'h1);
    check("ign_tx_count", tx_q.size(), 2);
    check("ign_tx_lo", tx_q.size() > 0 ? tx_q[0] : 8'hxx, 8'hFF);
    check("ign_tx_hi", tx_q.size() > 1 ? tx_q[1] : 8'hxx, 8'h00);

    // Reset mid-frame, then a clean write
    clear_log();
    send(8'hAA);
    send(8'h05);
    RST = 1'b1;
    tick();
    check_reset_outputs("midrst");
    RST = 1'b0;
    idle(1);
    send(8'hAA);
    send(8'h01);
    send(8'hFF);
    idle(3);
    check("rst_wr_count", wr_cnt, 1);
    check("rst_wr0", wr_q.size() > 0 ? wr_q[0] : 12'hxxx, {4'h1, 8'hFF});
    check("rst_no_tx", tx_q.size(), 0);

    check("wr_rd_exclusive", both_hi, 0);
    check("tx_never_when_full", tx_while_full, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
